// File: rtl/serial_add_if.sv
// Operand/result handshake bundle for the bit-serial add/subtract sequencer.
// The master side supplies operands and consumes results; the slave side is the sequencer.
interface serial_add_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one shared full-adder cell, one operand bit per clock, LSB first.
// Subtraction is A + ~B + 1, with the +1 preloaded into the carry flop.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst,
  serial_add_if.slave bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             carry_q, cout_q, ovf_q;
  logic             accept, step, last;
  logic [1:0]       fa;

  // Returns {carry, sum} of a single full-adder cell.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    full_add = {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  assign fa = full_add(a_q[0], b_q[0], carry_q);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == LAST_BIT) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Datapath: operand load on accept, one shift/add step per RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      a_q     <= bus.a;
      b_q     <= bus.sub ? ~bus.b : bus.b;
      carry_q <= bus.sub;
      cnt_q   <= '0;
    end else if (step) begin
      res_q   <= {fa[0], res_q[WIDTH-1:1]};
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      carry_q <= fa[1];
      if (last) begin
        cout_q <= fa[1];
        // carry_q here is the carry into the MSB cell
        ovf_q  <= carry_q ^ fa[1];
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = res_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8): table vectors, random ops and
// hand-written backpressure, back-to-back and reset-abort sequences with a result scoreboard.
module tb_serial_add_ctrl;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    exp_t         e;
    int           stall;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  vec_t vecs[6];

  serial_add_if #(.WIDTH(W)) bus ();

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sv);
    logic [W-1:0] bb;
    logic [W:0]   full;
    exp_t         e;
    bb   = sv ? ~bv : bv;
    full = {1'b0, av} + {1'b0, bb} + (W+1)'(sv);
    e.s  = full[W-1:0];
    e.c  = full[W];
    e.v  = (av[W-1] == bb[W-1]) && (full[W-1] != av[W-1]);
    return e;
  endfunction

  // Call right after the accept edge; counts edges until out_valid is seen.
  task automatic wait_valid(input bit garbage, output int n, output bit rdy_bad);
    n = 0;
    rdy_bad = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) break;
      if (bus.in_ready !== 1'b0) rdy_bad = 1'b1;
      if (n >= 40) begin
        check("valid_timeout", 32'(n), 32'(W));
        break;
      end
      if (garbage) begin
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        bus.sub      = 1'($urandom_range(0, 1));
        bus.in_valid = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      n++;
    end
  endtask

  task automatic compare_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(0), 32'(1));
      return;
    end
    e = sb.pop_front();
    check({tag, "_sum"},  32'(bus.sum),  32'(e.s));
    check({tag, "_cout"}, 32'(bus.cout), 32'(e.c));
    check({tag, "_ovf"},  32'(bus.ovf),  32'(e.v));
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic sv, input exp_t e, input int stall);
    int           n;
    bit           rdy_bad;
    logic [W-1:0] s0;
    logic         c0, v0;
    @(negedge clk);
    check({tag, "_in_ready_idle"}, 32'(bus.in_ready), 32'(1));
    bus.a = av; bus.b = bv; bus.sub = sv; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk);
    sb.push_back(e);
    wait_valid(1'b1, n, rdy_bad);
    check({tag, "_latency"}, 32'(n), 32'(W));
    check({tag, "_in_ready_run"}, 32'(rdy_bad), 32'(0));
    s0 = bus.sum; c0 = bus.cout; v0 = bus.ovf;
    for (int i = 0; i < stall; i++) begin
      bus.a = W'($urandom); bus.b = W'($urandom); bus.in_valid = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      check({tag, "_hold"}, {21'd0, bus.out_valid, bus.sum, bus.cout, bus.ovf},
            {21'd0, 1'b1, s0, c0, v0});
    end
    compare_result(tag);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_handoff"}, {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int n;
    bit rdy_bad;
    logic [W-1:0] ra, rb;
    logic rs;

    vecs[0] = '{a: 8'h03, b: 8'h05, sub: 1'b0, e: '{s: 8'h08, c: 1'b0, v: 1'b0}, stall: 0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, e: '{s: 8'h00, c: 1'b1, v: 1'b0}, stall: 0};
    vecs[2] = '{a: 8'h7F, b: 8'h01, sub: 1'b0, e: '{s: 8'h80, c: 1'b0, v: 1'b1}, stall: 1};
    vecs[3] = '{a: 8'h05, b: 8'h07, sub: 1'b1, e: '{s: 8'hFE, c: 1'b0, v: 1'b0}, stall: 0};
    vecs[4] = '{a: 8'h80, b: 8'h01, sub: 1'b1, e: '{s: 8'h7F, c: 1'b1, v: 1'b1}, stall: 5};
    vecs[5] = '{a: 8'h10, b: 8'h10, sub: 1'b1, e: '{s: 8'h00, c: 1'b1, v: 1'b0}, stall: 2};

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_state", {21'd0, bus.in_ready, bus.out_valid, bus.sum, bus.cout, bus.ovf},
          {21'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].e, vecs[i].stall);

    for (int i = 0; i < 4; i++) begin
      ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom_range(0, 1));
      run_op($sformatf("rnd%0d", i), ra, rb, rs, model(ra, rb, rs), i % 2);
    end

    // Back-to-back: in_valid and out_ready held high across two operations.
    @(negedge clk);
    bus.a = 8'h11; bus.b = 8'h22; bus.sub = 1'b0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(posedge clk);
    sb.push_back(model(8'h11, 8'h22, 1'b0));
    #1;
    bus.a = 8'h30; bus.b = 8'h05; bus.sub = 1'b1;
    wait_valid(1'b0, n, rdy_bad);
    check("b2b1_latency", 32'(n), 32'(W));
    compare_result("b2b1");
    @(posedge clk);
    @(negedge clk);
    check("b2b_idle_gap", {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
    @(posedge clk);
    sb.push_back(model(8'h30, 8'h05, 1'b1));
    @(negedge clk);
    check("b2b_second_accept", 32'(bus.in_ready), 32'(0));
    bus.in_valid = 1'b0;
    @(posedge clk);
    n = 0;
    wait_valid(1'b0, n, rdy_bad);
    check("b2b2_latency", 32'(n + 1), 32'(W));
    compare_result("b2b2");
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Reset during RUN discards the operation.
    @(negedge clk);
    bus.a = 8'h0F; bus.b = 8'h0F; bus.sub = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_run", {22'd0, bus.in_ready, bus.out_valid, bus.sum},
          {22'd0, 1'b1, 1'b0, 8'h00});
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", {30'd0, bus.in_ready, bus.out_valid}, 32'b10);
    run_op("after_rst", 8'h01, 8'h01, 1'b0, '{s: 8'h02, c: 1'b0, v: 1'b0}, 0);

    check("sb_drained", 32'(sb.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got running want finished");
    $fatal(1, "watchdog");
  end
endmodule
